// File: rtl/regfile_mp_if.sv
// Register-file bus bundle: write ports, read ports, debug read port and status.
// Latency: none; this is a plain signal bundle (reads combinational, writes on the rising clock edge).
// Backpressure: none; writes presented while o_ready is low are dropped by the register file.
// Ports: i_we/i_wr_addr/i_wr_data (NWR packed write ports), i_rd_addr/o_rd_data (NRD packed read ports),
//        i_RegDebug/o_RegDebug (debug read), o_ready, o_wr_conflict.
interface regfile_mp_if #(
    parameter int REGS  = 5,
    parameter int NBITS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    logic [NWR-1:0]       i_we;
    logic [NWR*REGS-1:0]  i_wr_addr;
    logic [NWR*NBITS-1:0] i_wr_data;
    logic [NRD*REGS-1:0]  i_rd_addr;
    logic [NRD*NBITS-1:0] o_rd_data;
    logic [REGS-1:0]      i_RegDebug;
    logic [NBITS-1:0]     o_RegDebug;
    logic                 o_ready;
    logic                 o_wr_conflict;

    // master: the decode stage / debug unit driving the register file
    modport master (
        output i_we, i_wr_addr, i_wr_data, i_rd_addr, i_RegDebug,
        input  o_rd_data, o_RegDebug, o_ready, o_wr_conflict
    );

    // slave: the register file itself
    modport slave (
        input  i_we, i_wr_addr, i_wr_data, i_rd_addr, i_RegDebug,
        output o_rd_data, o_RegDebug, o_ready, o_wr_conflict
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port MIPS register file with hardwired $zero and a post-reset init sequencer.
// Latency: reads combinational; writes commit on the rising edge; o_ready rises CELDAS edges after reset release.
// Backpressure: none; writes are silently dropped while o_ready is low.
// Ports: i_clk, i_reset (async active-low), bus (regfile_mp_if.slave: write/read/debug ports, o_ready, o_wr_conflict).
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports (debug port never forwards).
module regfile_mp #(
    parameter int REGS     = 5,
    parameter int NBITS    = 32,
    parameter int CELDAS   = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int INIT_IDX = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    regfile_mp_if.slave  bus
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [REGS-1:0] LAST = REGS'(CELDAS - 1);

    state_t            state_q, state_d;
    logic [REGS-1:0]   cnt_q;
    logic              ready;
    logic              init_wr;
    logic              conf_q, conf_d;
    logic [NBITS-1:0]  mem [CELDAS];
    logic [NRD*NBITS-1:0] rd_data;
    logic [NBITS-1:0]  dbg_data;

    // Register 0 is hardwired and out-of-range addresses have no backing cell.
    function automatic logic valid_addr(input logic [REGS-1:0] a);
        return (a != '0) && (32'(a) < 32'(CELDAS));
    endfunction

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            conf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT)
                cnt_q <= cnt_q + 1'b1;
            conf_q  <= conf_d;
        end
    end

    // Next-state logic: leave INIT once the last cell has been written
    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT && cnt_q == LAST)
            state_d = S_RUN;
    end

    // Output logic
    always_comb begin
        ready   = (state_q == S_RUN);
        init_wr = (state_q == S_INIT);
    end

    // Conflict detect only exists with two write ports; qualified by ready so it stays low during init.
    generate
        if (NWR == 2) begin : g_conf
            always_comb begin
                conf_d = ready && bus.i_we[0] && bus.i_we[1]
                      && (bus.i_wr_addr[0 +: REGS] == bus.i_wr_addr[REGS +: REGS])
                      && (bus.i_wr_addr[0 +: REGS] != '0);
            end
        end else begin : g_noconf
            always_comb conf_d = 1'b0;
        end
    endgenerate

    // Array has no reset; the sequencer fills it one cell per cycle instead.
    // Ports are visited in ascending order so the highest index wins on a clash.
    always_ff @(posedge i_clk) begin
        if (init_wr) begin
            mem[cnt_q] <= (INIT_IDX != 0) ? NBITS'(cnt_q) : '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (bus.i_we[k] && valid_addr(bus.i_wr_addr[k*REGS +: REGS]))
                    mem[bus.i_wr_addr[k*REGS +: REGS]] <= bus.i_wr_data[k*NBITS +: NBITS];
            end
        end
    end

    // Read ports
    always_comb begin
        rd_data = '0;
        for (int j = 0; j < NRD; j++) begin
            logic [REGS-1:0]  ra;
            logic [NBITS-1:0] val;
            ra  = bus.i_rd_addr[j*REGS +: REGS];
            val = '0;
            if (ready && valid_addr(ra)) begin
                val = mem[ra];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < NWR; k++) begin
                    if (bus.i_we[k] && bus.i_wr_addr[k*REGS +: REGS] == ra)
                        val = bus.i_wr_data[k*NBITS +: NBITS];
                end
`endif
            end
            rd_data[j*NBITS +: NBITS] = val;
        end
    end

    // Debug port shows committed contents only
    always_comb begin
        dbg_data = '0;
        if (ready && valid_addr(bus.i_RegDebug))
            dbg_data = mem[bus.i_RegDebug];
    end

    assign bus.o_rd_data     = rd_data;
    assign bus.o_RegDebug    = dbg_data;
    assign bus.o_ready       = ready;
    assign bus.o_wr_conflict = conf_q;
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    localparam int REGS = 5, NBITS = 32, CELDAS = 32, NRD = 2, NWR = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_mp_if #(.REGS(REGS), .NBITS(NBITS), .NRD(NRD), .NWR(NWR)) bus();

    regfile_mp #(.REGS(REGS), .NBITS(NBITS), .CELDAS(CELDAS), .NRD(NRD), .NWR(NWR), .INIT_IDX(1)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: committed register contents plus the pending conflict flag
    logic [31:0] ref_mem [CELDAS];
    logic        ref_conf;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1, dbg;
        logic [31:0] e_rd0, e_rd1, e_dbg;
        logic        e_conf;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] dbg,
                                input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                                input logic [31:0] e_dbg, input logic e_conf);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ra0 = ra0; v.ra1 = ra1; v.dbg = dbg;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_dbg = e_dbg; v.e_conf = e_conf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.i_we       = v.we;
        bus.i_wr_addr  = {v.wa1, v.wa0};
        bus.i_wr_data  = {v.wd1, v.wd0};
        bus.i_rd_addr  = {v.ra1, v.ra0};
        bus.i_RegDebug = v.dbg;
    endtask

    function automatic logic [31:0] model_rd(input vec_t v, input logic [4:0] ra);
        logic [31:0] r;
        if (ra == 0) return 32'h0;
        r = ref_mem[ra];
        if (BYP) begin
            if (v.we[1] && v.wa1 == ra) r = v.wd1;
            else if (v.we[0] && v.wa0 == ra) r = v.wd0;
        end
        return r;
    endfunction

    // Apply the rules for one committed RUN cycle: $zero never written, port 1 applied last.
    task automatic model_commit(input vec_t v);
        ref_conf = (v.we == 2'b11) && (v.wa0 == v.wa1) && (v.wa0 != 0);
        if (v.we[0] && v.wa0 != 0) ref_mem[v.wa0] = v.wd0;
        if (v.we[1] && v.wa1 != 0) ref_mem[v.wa1] = v.wd1;
    endtask

    task automatic model_init();
        for (int i = 0; i < CELDAS; i++) ref_mem[i] = i;
        ref_conf = 1'b0;
    endtask

    // One RUN cycle: drive after the previous edge, check at negedge, commit at posedge.
    task automatic run_cycle(input vec_t v, input bit use_model, input string tag);
        vec_t e;
        drive(v);
        @(negedge clk);
        e = v;
        if (use_model) begin
            e.e_rd0  = model_rd(v, v.ra0);
            e.e_rd1  = model_rd(v, v.ra1);
            e.e_dbg  = (v.dbg == 0) ? 32'h0 : ref_mem[v.dbg];
            e.e_conf = ref_conf;
        end
        chk({tag, ".rd0"},  bus.o_rd_data[31:0],  e.e_rd0);
        chk({tag, ".rd1"},  bus.o_rd_data[63:32], e.e_rd1);
        chk({tag, ".dbg"},  bus.o_RegDebug,       e.e_dbg);
        chk({tag, ".conf"}, bus.o_wr_conflict,    e.e_conf);
        chk({tag, ".ready"}, bus.o_ready,         1);
        @(posedge clk);
        model_commit(v);
        #1;
    endtask

    // Counts edges from release until o_ready rises; outputs must stay quiet meanwhile.
    task automatic wait_ready(output int edges);
        edges = 0;
        while (edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.o_ready) break;
            chk("init.rd0",  bus.o_rd_data[31:0], 0);
            chk("init.conf", bus.o_wr_conflict,   0);
        end
    endtask

    initial begin
        int   e;
        vec_t v;

        rst_n = 1'b0;
        drive(mk(2'b00, 0, 0, 0, 0, 5, 31, 5, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.ready", bus.o_ready, 0);
        chk("reset.conf",  bus.o_wr_conflict, 0);
        chk("reset.rd0",   bus.o_rd_data[31:0], 0);
        chk("reset.dbg",   bus.o_RegDebug, 0);

        // Release with writes pending; they must be ignored during init.
        rst_n = 1'b1;
        drive(mk(2'b11, 3, 32'hBAD0, 3, 32'hBAD1, 5, 3, 5, 0, 0, 0, 0));
        wait_ready(e);
        chk("init_edges", e, CELDAS);
        drive(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        model_init();

        tbl[0]  = mk(2'b00, 0, 0, 0, 0,                          5, 3, 31, 5, 3, 31, 0);
        tbl[1]  = mk(2'b01, 7, 32'hDEADBEEF, 0, 0,               7, 0, 7,
                     BYP ? 32'hDEADBEEF : 32'd7, 0, 7, 0);
        tbl[2]  = mk(2'b00, 0, 0, 0, 0,                          7, 5, 7, 32'hDEADBEEF, 5, 32'hDEADBEEF, 0);
        tbl[3]  = mk(2'b01, 0, 32'h12345678, 0, 0,               0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(2'b00, 0, 0, 0, 0,                          0, 1, 0, 0, 1, 0, 0);
        tbl[5]  = mk(2'b11, 9, 32'h1111, 9, 32'h2222,            9, 9, 9,
                     BYP ? 32'h2222 : 32'd9, BYP ? 32'h2222 : 32'd9, 9, 0);
        tbl[6]  = mk(2'b00, 0, 0, 0, 0,                          9, 31, 9, 32'h2222, 31, 32'h2222, 1);
        tbl[7]  = mk(2'b00, 0, 0, 0, 0,                          31, 9, 31, 31, 32'h2222, 31, 0);
        tbl[8]  = mk(2'b11, 12, 32'hAAA, 13, 32'hBBB,            12, 13, 12,
                     BYP ? 32'hAAA : 32'd12, BYP ? 32'hBBB : 32'd13, 12, 0);
        tbl[9]  = mk(2'b00, 0, 0, 0, 0,                          12, 13, 13, 32'hAAA, 32'hBBB, 32'hBBB, 0);
        tbl[10] = mk(2'b11, 0, 32'h5A5A, 0, 32'hA5A5,            0, 2, 0, 0, 2, 0, 0);
        tbl[11] = mk(2'b00, 0, 0, 0, 0,                          0, 2, 2, 0, 2, 2, 0);

        for (int i = 0; i < 12; i++) run_cycle(tbl[i], 1'b0, $sformatf("tbl%0d", i));

        // Randomized traffic against the model; reads often aim at the write addresses.
        for (int i = 0; i < 400; i++) begin
            v = mk(2'($urandom_range(0, 3)), 5'($urandom), $urandom, 5'($urandom), $urandom,
                   5'($urandom), 5'($urandom), 5'($urandom), 0, 0, 0, 0);
            if ($urandom_range(0, 3) == 0) v.wa1 = v.wa0;
            if ($urandom_range(0, 1) == 0) v.ra0 = v.wa0;
            if ($urandom_range(0, 1) == 0) v.ra1 = v.wa1;
            run_cycle(v, 1'b1, "rnd");
        end

        // Write reg 3, then reset mid-RUN and again mid-INIT; re-init must restore it.
        run_cycle(mk(2'b01, 3, 32'hAAAA, 0, 0, 3, 0, 3, 0, 0, 0, 0), 1'b1, "pre_rst_wr");
        run_cycle(mk(2'b00, 0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 0), 1'b1, "pre_rst_rd");
        rst_n = 1'b0;
        #1;
        chk("rst_run.ready", bus.o_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_init.ready", bus.o_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_init_rst.ready", bus.o_ready, 0);
        rst_n = 1'b1;
        drive(mk(2'b11, 4, 32'h5555, 4, 32'h6666, 4, 3, 4, 0, 0, 0, 0));
        wait_ready(e);
        chk("reinit_edges", e, CELDAS);
        drive(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        model_init();
        run_cycle(mk(2'b00, 0, 0, 0, 0, 3, 4, 3, 3, 4, 3, 0), 1'b0, "reinit_r3");
        run_cycle(mk(2'b00, 0, 0, 0, 0, 4, 0, 4, 4, 0, 4, 0), 1'b0, "reinit_r4");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
